// File: rtl/csr_irq_ctrl.sv
// Machine-mode CSR file with interrupt/ecall trap entry and mret return sequencing.
// Define CSR_VECTORED_EN to make mtvec.MODE writable and vector interrupts to base + 4*code.
module csr_irq_ctrl #(
  parameter int XLEN = 64,
  parameter logic [XLEN-1:0] RESET_MTVEC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_i,
  input  logic [3:0]      csr_ctl,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  input  logic            core_valid,
  input  logic            retire,
  input  logic            irq_soft,
  input  logic            irq_timer,
  input  logic            irq_ext,
  output logic [XLEN-1:0] csr_rdata,
  output logic            illegal_csr,
  output logic            trap_valid,
  input  logic            trap_ready,
  output logic [XLEN-1:0] trap_pc
);

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MIP       = 12'h344;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;

  typedef enum logic [1:0] {IDLE, TAKE, REDIRECT} state_t;
  state_t state, state_nxt;

  logic csr_wr, csr_rd, ecall, mret;
  assign {csr_wr, csr_rd, ecall, mret} = csr_ctl;

  logic            st_mie, st_mpie;
  logic [1:0]      st_mpp;
  logic            en_msi, en_mti, en_mei;
  logic            ip_msi, ip_mti, ip_mei;
  logic [XLEN-3:0] mtvec_base;
  logic            vec_mode;
  logic [XLEN-1:0] mscratch, mcause;
  logic [XLEN-3:0] mepc_base;
  logic [63:0]     mcycle, minstret, mcycle_nxt, minstret_nxt, wdata64;
  logic [XLEN-3:0] take_pc;
  logic [XLEN-1:0] take_cause, trap_pc_q;
  logic            impl, wr_en, irq_pend, take_start, mret_go;
  logic [XLEN-1:0] rd_val, cause_nxt, vec_target;
  logic            unused_pc_bits;

  assign unused_pc_bits = ^pc_i[1:0];
  assign wdata64        = 64'(csr_wdata);

  // Address decode and read mux; unimplemented addresses read as zero.
  always_comb begin
    impl   = 1'b1;
    rd_val = '0;
    case (csr_addr)
      A_MSTATUS: begin
        rd_val[3]     = st_mie;
        rd_val[7]     = st_mpie;
        rd_val[12:11] = st_mpp;
      end
      A_MIE: begin
        rd_val[3]  = en_msi;
        rd_val[7]  = en_mti;
        rd_val[11] = en_mei;
      end
      A_MTVEC:    rd_val = {mtvec_base, 1'b0, vec_mode};
      A_MSCRATCH: rd_val = mscratch;
      A_MEPC:     rd_val = {mepc_base, 2'b00};
      A_MCAUSE:   rd_val = mcause;
      A_MIP: begin
        rd_val[3]  = ip_msi;
        rd_val[7]  = ip_mti;
        rd_val[11] = ip_mei;
      end
      A_MCYCLE:   rd_val = mcycle[XLEN-1:0];
      A_MINSTRET: rd_val = minstret[XLEN-1:0];
      A_MCYCLEH: begin
        if (XLEN == 32) rd_val = XLEN'(mcycle[63:32]);
        else            impl   = 1'b0;
      end
      A_MINSTRETH: begin
        if (XLEN == 32) rd_val = XLEN'(minstret[63:32]);
        else            impl   = 1'b0;
      end
      default: impl = 1'b0;
    endcase
  end

  assign csr_rdata   = rd_val;
  assign illegal_csr = (csr_wr | csr_rd) & ~impl;
  assign wr_en       = csr_wr & impl;

  // A CSR write replaces the counter (or just the addressed half) instead of incrementing it.
  always_comb begin
    mcycle_nxt   = mcycle + 64'd1;
    minstret_nxt = minstret + {63'd0, retire};
    if (wr_en) begin
      case (csr_addr)
        A_MCYCLE:    mcycle_nxt   = (XLEN == 32) ? {mcycle[63:32], wdata64[31:0]} : wdata64;
        A_MCYCLEH:   mcycle_nxt   = {wdata64[31:0], mcycle[31:0]};
        A_MINSTRET:  minstret_nxt = (XLEN == 32) ? {minstret[63:32], wdata64[31:0]} : wdata64;
        A_MINSTRETH: minstret_nxt = {wdata64[31:0], minstret[31:0]};
        default: ;
      endcase
    end
  end

  assign irq_pend = st_mie & ((ip_msi & en_msi) | (ip_mti & en_mti) | (ip_mei & en_mei));

  always_comb begin
    cause_nxt = '0;
    if (ecall) begin
      cause_nxt[3:0] = 4'd11;
    end else begin
      cause_nxt[XLEN-1] = 1'b1;
      if (ip_mei & en_mei)      cause_nxt[3:0] = 4'd11;
      else if (ip_msi & en_msi) cause_nxt[3:0] = 4'd3;
      else                      cause_nxt[3:0] = 4'd7;
    end
  end

  always_comb begin
    vec_target = {mtvec_base, 2'b00};
    if (vec_mode && take_cause[XLEN-1])
      vec_target = vec_target + XLEN'({take_cause[3:0], 2'b00});
  end

  // Trap entry (ecall, then interrupts) has priority over mret when both arrive in IDLE.
  always_comb begin
    state_nxt  = state;
    take_start = 1'b0;
    mret_go    = 1'b0;
    case (state)
      IDLE: begin
        if (!core_valid) begin
          if (ecall || irq_pend) begin
            state_nxt  = TAKE;
            take_start = 1'b1;
          end else if (mret) begin
            state_nxt = REDIRECT;
            mret_go   = 1'b1;
          end
        end
      end
      TAKE:     state_nxt = REDIRECT;
      REDIRECT: if (trap_ready) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  assign trap_valid = (state == REDIRECT);
  assign trap_pc    = trap_pc_q;

  // The redirect target is captured once on entry to REDIRECT so later mtvec/mepc writes cannot move it.
  always_ff @(posedge clk) begin
    if (rst) begin
      take_pc    <= '0;
      take_cause <= '0;
      trap_pc_q  <= '0;
    end else begin
      if (take_start) begin
        take_pc    <= pc_i[XLEN-1:2];
        take_cause <= cause_nxt;
      end
      if (state == TAKE) trap_pc_q <= vec_target;
      else if (mret_go)  trap_pc_q <= {mepc_base, 2'b00};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_mie  <= 1'b0;
      st_mpie <= 1'b0;
      st_mpp  <= 2'b00;
    end else if (state == TAKE) begin
      st_mpie <= st_mie;
      st_mie  <= 1'b0;
      st_mpp  <= 2'b11;
    end else if (mret_go) begin
      st_mie  <= st_mpie;
      st_mpie <= 1'b1;
      st_mpp  <= 2'b00;
    end else if (wr_en && csr_addr == A_MSTATUS) begin
      st_mie  <= csr_wdata[3];
      st_mpie <= csr_wdata[7];
      st_mpp  <= csr_wdata[12:11];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mepc_base <= '0;
      mcause    <= '0;
    end else if (state == TAKE) begin
      mepc_base <= take_pc;
      mcause    <= take_cause;
    end else if (wr_en) begin
      if (csr_addr == A_MEPC)   mepc_base <= csr_wdata[XLEN-1:2];
      if (csr_addr == A_MCAUSE) mcause    <= csr_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_msi     <= 1'b0;
      en_mti     <= 1'b0;
      en_mei     <= 1'b0;
      mtvec_base <= RESET_MTVEC[XLEN-1:2];
      mscratch   <= '0;
      ip_msi     <= 1'b0;
      ip_mti     <= 1'b0;
      ip_mei     <= 1'b0;
      mcycle     <= '0;
      minstret   <= '0;
    end else begin
      if (wr_en && csr_addr == A_MIE) begin
        en_msi <= csr_wdata[3];
        en_mti <= csr_wdata[7];
        en_mei <= csr_wdata[11];
      end
      if (wr_en && csr_addr == A_MTVEC)    mtvec_base <= csr_wdata[XLEN-1:2];
      if (wr_en && csr_addr == A_MSCRATCH) mscratch   <= csr_wdata;
      ip_msi   <= irq_soft;
      ip_mti   <= irq_timer;
      ip_mei   <= irq_ext;
      mcycle   <= mcycle_nxt;
      minstret <= minstret_nxt;
    end
  end

`ifdef CSR_VECTORED_EN
  // Only direct (0) and vectored (1) modes exist; reserved modes 2 and 3 fall back to direct.
  always_ff @(posedge clk) begin
    if (rst)                                 vec_mode <= (RESET_MTVEC[1:0] == 2'b01);
    else if (wr_en && csr_addr == A_MTVEC)   vec_mode <= (csr_wdata[1:0] == 2'b01);
  end
`else
  assign vec_mode = 1'b0;
`endif

endmodule

// File: tb/tb_csr_irq_ctrl.sv
// Randomized and directed bench for csr_irq_ctrl against a transaction-level CSR/trap model.
// A 32-bit instance covers the split counter halves.
module tb_csr_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] pc_i, csr_wdata, csr_rdata, trap_pc;
  logic [3:0]  csr_ctl;
  logic [11:0] csr_addr;
  logic        core_valid, retire, irq_soft, irq_timer, irq_ext;
  logic        illegal_csr, trap_valid, trap_ready;

  logic [31:0] s32_wdata, s32_rdata, s32_trap_pc;
  logic [3:0]  s32_ctl;
  logic [11:0] s32_addr;
  logic        s32_retire, s32_illegal, s32_trap_valid;

  int vectors = 0;
  int miscompares = 0;

  always #10 clk = ~clk;

  csr_irq_ctrl #(.XLEN(64), .RESET_MTVEC(64'h100)) dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .csr_ctl(csr_ctl), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .core_valid(core_valid), .retire(retire),
    .irq_soft(irq_soft), .irq_timer(irq_timer), .irq_ext(irq_ext),
    .csr_rdata(csr_rdata), .illegal_csr(illegal_csr), .trap_valid(trap_valid),
    .trap_ready(trap_ready), .trap_pc(trap_pc)
  );

  csr_irq_ctrl #(.XLEN(32), .RESET_MTVEC(32'h0)) dut32 (
    .clk(clk), .rst(rst), .pc_i(32'h0), .csr_ctl(s32_ctl), .csr_addr(s32_addr),
    .csr_wdata(s32_wdata), .core_valid(1'b1), .retire(s32_retire),
    .irq_soft(1'b0), .irq_timer(1'b0), .irq_ext(1'b0),
    .csr_rdata(s32_rdata), .illegal_csr(s32_illegal), .trap_valid(s32_trap_valid),
    .trap_ready(1'b1), .trap_pc(s32_trap_pc)
  );

  // Reference model: architectural CSR values plus a pending-entry flag and an outstanding redirect.
  logic [63:0] m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mip;
  logic [63:0] m_mcycle, m_minstret, m_take_pc, m_take_cause, m_redirect_pc;
  bit          m_take_due, m_redirect;

  function automatic bit model_legal(input logic [11:0] a);
    return a inside {12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h344, 12'hB00, 12'hB02};
  endfunction

  function automatic logic [63:0] model_read(input logic [11:0] a);
    case (a)
      12'h300: return m_mstatus;
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h344: return m_mip;
      12'hB00: return m_mcycle;
      12'hB02: return m_minstret;
      default: return 64'd0;
    endcase
  endfunction

  task automatic model_step();
    logic [63:0] old_status, old_mtvec, old_mepc, pend, tgt;
    if (rst) begin
      {m_mstatus, m_mie, m_mscratch, m_mepc, m_mcause, m_mip, m_mcycle, m_minstret} = '0;
      m_mtvec = 64'h100;
      m_take_due = 0;
      m_redirect = 0;
      return;
    end
    old_status = m_mstatus;
    old_mtvec  = m_mtvec;
    old_mepc   = m_mepc;
    pend       = m_mip & m_mie;
    m_mcycle   = m_mcycle + 1;
    m_minstret = m_minstret + 64'(retire);
    if (csr_ctl[3] && model_legal(csr_addr)) begin
      case (csr_addr)
        12'h300: m_mstatus = csr_wdata & 64'h1888;
        12'h304: m_mie = csr_wdata & 64'h888;
`ifdef CSR_VECTORED_EN
        12'h305: m_mtvec = (csr_wdata & ~64'h3) | ((csr_wdata[1:0] == 2'b01) ? 64'd1 : 64'd0);
`else
        12'h305: m_mtvec = csr_wdata & ~64'h3;
`endif
        12'h340: m_mscratch = csr_wdata;
        12'h341: m_mepc = csr_wdata & ~64'h3;
        12'h342: m_mcause = csr_wdata;
        12'hB00: m_mcycle = csr_wdata;
        12'hB02: m_minstret = csr_wdata;
        default: ;
      endcase
    end
    if (m_take_due) begin
      m_mepc    = m_take_pc & ~64'h3;
      m_mcause  = m_take_cause;
      m_mstatus = (64'(old_status[3]) << 7) | 64'h1800;
      tgt = old_mtvec & ~64'h3;
      if (old_mtvec[1:0] == 2'b01 && m_take_cause[63]) tgt = tgt + (m_take_cause & 64'hF) * 4;
      m_redirect_pc = tgt;
      m_take_due = 0;
      m_redirect = 1;
    end else if (m_redirect) begin
      if (trap_ready) m_redirect = 0;
    end else if (!core_valid) begin
      if (csr_ctl[1]) begin
        m_take_due = 1;
        m_take_pc = pc_i;
        m_take_cause = 64'd11;
      end else if (pend != 0 && old_status[3]) begin
        m_take_due = 1;
        m_take_pc = pc_i;
        m_take_cause = pend[11] ? 64'h8000_0000_0000_000B :
                       pend[3]  ? 64'h8000_0000_0000_0003 : 64'h8000_0000_0000_0007;
      end else if (csr_ctl[0]) begin
        m_mstatus = 64'h80 | (64'(old_status[7]) << 3);
        m_redirect_pc = old_mepc;
        m_redirect = 1;
      end
    end
    m_mip = (64'(irq_ext) << 11) | (64'(irq_timer) << 7) | (64'(irq_soft) << 3);
  endtask

  always @(posedge clk) model_step();

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_csr(input logic [11:0] a, input logic [63:0] d);
    csr_ctl = 4'b1000;
    csr_addr = a;
    csr_wdata = d;
    applyStimulus(1);
    csr_ctl = 4'b0000;
  endtask

  task automatic check_csr(input string tag, input logic [11:0] a, input logic [63:0] exp);
    csr_ctl = 4'b0100;
    csr_addr = a;
    #1;
    checkOutput(tag, csr_rdata, exp);
  endtask

  task automatic check_s32(input string tag, input logic [11:0] a, input logic [31:0] exp);
    s32_ctl = 4'b0100;
    s32_addr = a;
    #1;
    checkOutput(tag, 64'(s32_rdata), 64'(exp));
  endtask

  logic [11:0] addr_tab [12] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                                 12'h344, 12'hB00, 12'hB02, 12'hB80, 12'h7C0, 12'h123};

  initial begin
    rst = 1'b1; pc_i = '0; csr_ctl = '0; csr_addr = '0; csr_wdata = '0;
    core_valid = 1'b1; retire = 1'b0; irq_soft = 1'b0; irq_timer = 1'b0; irq_ext = 1'b0;
    trap_ready = 1'b0; s32_ctl = '0; s32_addr = '0; s32_wdata = '0; s32_retire = 1'b0;
    applyStimulus(2);
    checkOutput("rst_trap_valid", 64'(trap_valid), 64'd0);
    check_csr("rst_mstatus", 12'h300, 64'd0);
    check_csr("rst_mtvec", 12'h305, 64'h100);
    check_csr("rst_mepc", 12'h341, 64'd0);
    applyStimulus(1);
    check_csr("rst_mcycle", 12'hB00, 64'd0);
    check_csr("rst_mip", 12'h344, 64'd0);
    rst = 1'b0;
    core_valid = 1'b0;

    // ecall entry and a held redirect
    write_csr(12'h305, 64'h8000_0000);
    pc_i = 64'h8000_0100;
    csr_ctl = 4'b0010;
    applyStimulus(1);
    csr_ctl = 4'b0000;
    checkOutput("take_no_valid", 64'(trap_valid), 64'd0);
    applyStimulus(1);
    check_csr("ecall_mepc", 12'h341, 64'h8000_0100);
    check_csr("ecall_mcause", 12'h342, 64'd11);
    check_csr("ecall_mstatus", 12'h300, 64'h1800);
    for (int i = 0; i < 3; i++) begin
      checkOutput("hold_valid", 64'(trap_valid), 64'd1);
      checkOutput("hold_pc", trap_pc, 64'h8000_0000);
      applyStimulus(1);
    end
    trap_ready = 1'b1;
    applyStimulus(1);
    trap_ready = 1'b0;
    checkOutput("ack_valid", 64'(trap_valid), 64'd0);

    // simultaneous timer+external: external wins
    write_csr(12'h300, 64'h8);
    write_csr(12'h304, 64'h888);
    pc_i = 64'h8000_0200;
    irq_timer = 1'b1;
    irq_ext = 1'b1;
    applyStimulus(2);
    irq_ext = 1'b0;
    applyStimulus(1);
    check_csr("mei_mcause", 12'h342, 64'h8000_0000_0000_000B);
    check_csr("mei_mstatus", 12'h300, 64'h1880);
    check_csr("mei_mepc", 12'h341, 64'h8000_0200);
    checkOutput("mei_pc", trap_pc, 64'h8000_0000);
    trap_ready = 1'b1;
    applyStimulus(1);
    trap_ready = 1'b0;

    // mret restores MIE from MPIE and redirects to mepc
    csr_ctl = 4'b0001;
    applyStimulus(1);
    csr_ctl = 4'b0000;
    checkOutput("mret_valid", 64'(trap_valid), 64'd1);
    checkOutput("mret_pc", trap_pc, 64'h8000_0200);
    check_csr("mret_mstatus", 12'h300, 64'h88);
    trap_ready = 1'b1;
    applyStimulus(1);
    trap_ready = 1'b0;
    pc_i = 64'h8000_0300;
    applyStimulus(2);
    check_csr("mti_mcause", 12'h342, 64'h8000_0000_0000_0007);
    check_csr("mti_mepc", 12'h341, 64'h8000_0300);
    trap_ready = 1'b1;
    applyStimulus(1);
    trap_ready = 1'b0;

    // vectored mtvec with a timer interrupt, then an ecall that must use the base
    write_csr(12'h305, 64'h8000_0001);
`ifdef CSR_VECTORED_EN
    check_csr("vec_mtvec", 12'h305, 64'h8000_0001);
`else
    check_csr("vec_mtvec", 12'h305, 64'h8000_0000);
`endif
    write_csr(12'h304, 64'h80);
    write_csr(12'h300, 64'h8);
    applyStimulus(2);
    checkOutput("vec_valid", 64'(trap_valid), 64'd1);
`ifdef CSR_VECTORED_EN
    checkOutput("vec_pc", trap_pc, 64'h8000_001C);
`else
    checkOutput("vec_pc", trap_pc, 64'h8000_0000);
`endif
    irq_timer = 1'b0;
    trap_ready = 1'b1;
    applyStimulus(1);
    trap_ready = 1'b0;
    pc_i = 64'h8000_0400;
    csr_ctl = 4'b0010;
    applyStimulus(1);
    csr_ctl = 4'b0000;
    applyStimulus(1);
    checkOutput("exc_base_pc", trap_pc, 64'h8000_0000);

    // reset during REDIRECT aborts it
    rst = 1'b1;
    applyStimulus(1);
    rst = 1'b0;
    checkOutput("rst_abort_valid", 64'(trap_valid), 64'd0);
    check_csr("rst_abort_mepc", 12'h341, 64'd0);
    check_csr("illegal_rdata", 12'h7C0, 64'd0);
    checkOutput("illegal_flag", 64'(illegal_csr), 64'd1);
    check_csr("illegal_h64", 12'hB80, 64'd0);
    checkOutput("illegal_h64_flag", 64'(illegal_csr), 64'd1);

    // counter write wins over increment
    write_csr(12'hB00, 64'd5);
    check_csr("mcycle_wr", 12'hB00, 64'd5);
    applyStimulus(1);
    check_csr("mcycle_inc", 12'hB00, 64'd6);

    // 32-bit halves
    s32_ctl = 4'b1000; s32_addr = 12'hB02; s32_wdata = 32'hFFFF_FFFF;
    applyStimulus(1);
    check_s32("s32_minstret", 12'hB02, 32'hFFFF_FFFF);
    check_s32("s32_minstreth0", 12'hB82, 32'd0);
    s32_retire = 1'b1;
    applyStimulus(1);
    s32_retire = 1'b0;
    check_s32("s32_minstreth1", 12'hB82, 32'd1);
    check_s32("s32_minstret0", 12'hB02, 32'd0);
    s32_ctl = 4'b1000; s32_addr = 12'hB80; s32_wdata = 32'd7;
    applyStimulus(1);
    check_s32("s32_mcycleh", 12'hB80, 32'd7);
    checkOutput("s32_no_trap", 64'(s32_trap_valid), 64'd0);

    // randomized traffic against the model
    for (int n = 0; n < 800; n++) begin
      rst        = ($urandom_range(99) == 0);
      core_valid = ($urandom_range(3) == 0);
      retire     = $urandom_range(1);
      irq_soft   = ($urandom_range(3) == 0);
      irq_timer  = ($urandom_range(3) == 0);
      irq_ext    = ($urandom_range(5) == 0);
      trap_ready = ($urandom_range(2) == 0);
      pc_i       = {$urandom, $urandom};
      csr_wdata  = {$urandom, $urandom};
      csr_addr   = addr_tab[$urandom_range(11)];
      csr_ctl    = {($urandom_range(3) == 0), 1'($urandom_range(1)),
                    ($urandom_range(15) == 0), ($urandom_range(15) == 0)};
      if (csr_ctl[0]) csr_ctl[3] = 1'b0;
      #1;
      checkOutput("rnd_trap_valid", 64'(trap_valid), 64'(m_redirect));
      if (m_redirect) checkOutput("rnd_trap_pc", trap_pc, m_redirect_pc);
      checkOutput("rnd_illegal", 64'(illegal_csr),
                  64'((csr_ctl[3] | csr_ctl[2]) & !model_legal(csr_addr)));
      checkOutput("rnd_rdata", csr_rdata, model_read(csr_addr));
      applyStimulus(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
